// File: rtl/sdram_bridge_pkg.sv
// Shared types, widths and lane helpers for the halfword-to-word SDRAM bridge.
package sdram_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int SDRAM_AW = 16;
    localparam int SDRAM_DW = 32;
    localparam int CPU_AW   = 17;
    localparam int CPU_DW   = 16;

    function automatic logic [3:0] lane_be(input logic hi, input logic [1:0] be);
        return hi ? {be, 2'b00} : {2'b00, be};
    endfunction

    function automatic logic [CPU_DW-1:0] lane_sel(input logic hi, input logic [SDRAM_DW-1:0] d);
        return hi ? d[31:16] : d[15:0];
    endfunction

endpackage

// File: rtl/sdram_read_buffer.sv
// One-entry read cache for the SDRAM bridge (used only with SDRAM_READ_BUFFER_EN).
module sdram_read_buffer
    import sdram_bridge_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [SDRAM_AW-1:0] lookup_addr_i,
    output logic                hit_o,
    output logic [SDRAM_DW-1:0] hit_data_o,
    input  logic                fill_en_i,
    input  logic [SDRAM_AW-1:0] fill_addr_i,
    input  logic [SDRAM_DW-1:0] fill_data_i,
    input  logic                inv_en_i,
    input  logic [SDRAM_AW-1:0] inv_addr_i,
    input  logic                inv_all_i
);

    logic                valid_q;
    logic [SDRAM_AW-1:0] addr_q;
    logic [SDRAM_DW-1:0] data_q;

    assign hit_o      = valid_q && (addr_q == lookup_addr_i);
    assign hit_data_o = data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (inv_all_i || (inv_en_i && valid_q && addr_q == inv_addr_i)) begin
            valid_q <= 1'b0;
        end else if (fill_en_i) begin
            valid_q <= 1'b1;
            addr_q  <= fill_addr_i;
            data_q  <= fill_data_i;
        end
    end

endmodule

// File: rtl/sdram_master_bridge.sv
// CPU halfword port to 32-bit SDRAM slave bridge with acknowledge timeout.
// Optional one-entry read buffer enabled by defining SDRAM_READ_BUFFER_EN.
module sdram_master_bridge
    import sdram_bridge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        mem_req,
    output logic        mem_ready,
    input  logic        mem_we,
    input  logic [16:0] mem_addr,
    input  logic [1:0]  mem_be,
    input  logic [15:0] mem_wdata,
    output logic        mem_resp_valid,
    output logic        mem_resp_err,
    output logic [15:0] mem_rdata,
    output logic [15:0] sdram_address,
    output logic [3:0]  sdram_byte_enable,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [31:0] sdram_write_data,
    input  logic        sdram_acknowledge,
    input  logic [31:0] sdram_read_data
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [SDRAM_AW-1:0] addr_q;
    logic [3:0]          be_q;
    logic [SDRAM_DW-1:0] wdata_q;
    logic                hi_q;
    logic [CPU_DW-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                transfer;
    logic                buf_hit;
    logic [SDRAM_DW-1:0] buf_data;

    assign mem_ready         = (state_q == IDLE);
    assign transfer          = mem_req && mem_ready;
    assign sdram_read        = (state_q == READ);
    assign sdram_write       = (state_q == WRITE);
    assign mem_resp_valid    = (state_q == RESP);
    assign mem_resp_err      = (state_q == RESP) && err_q;
    assign mem_rdata         = rdata_q;
    assign sdram_address     = addr_q;
    assign sdram_byte_enable = be_q;
    assign sdram_write_data  = wdata_q;

`ifdef SDRAM_READ_BUFFER_EN
    logic fill_en;
    logic tmo_abort;

    assign fill_en   = sdram_read && sdram_acknowledge;
    assign tmo_abort = (sdram_read || sdram_write) && !sdram_acknowledge && (cnt_q == TMO_LAST);

    // Any write to the buffered word invalidates it at transfer, even one with no byte enables.
    sdram_read_buffer u_read_buffer (
        .clk_i         (clk_clk),
        .rst_ni        (reset_reset_n),
        .lookup_addr_i (mem_addr[16:1]),
        .hit_o         (buf_hit),
        .hit_data_o    (buf_data),
        .fill_en_i     (fill_en),
        .fill_addr_i   (addr_q),
        .fill_data_i   (sdram_read_data),
        .inv_en_i      (transfer && mem_we),
        .inv_addr_i    (mem_addr[16:1]),
        .inv_all_i     (tmo_abort)
    );
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    cnt_d = '0;
                    err_d = 1'b0;
                    if (mem_we) begin
                        state_d = (mem_be == 2'b00) ? RESP : WRITE;
                    end else if (buf_hit) begin
                        state_d = RESP;
                        rdata_d = lane_sel(mem_addr[0], buf_data);
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ, WRITE: begin
                // Acknowledge takes priority over a timeout expiring in the same cycle.
                if (sdram_acknowledge) begin
                    state_d = RESP;
                    if (state_q == READ) begin
                        rdata_d = lane_sel(hi_q, sdram_read_data);
                    end
                end else if (cnt_q == TMO_LAST) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            hi_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (transfer) begin
                addr_q  <= mem_addr[16:1];
                hi_q    <= mem_addr[0];
                be_q    <= mem_we ? lane_be(mem_addr[0], mem_be) : 4'hF;
                wdata_q <= {mem_wdata, mem_wdata};
            end
        end
    end

endmodule

// File: doc/sdram_master_bridge.md
# sdram_master_bridge

Initiator for the fabric's 32-bit SDRAM slave port (address / byte-enable / read / write / acknowledge). It converts single 16-bit halfword accesses from the stack CPU memory port into one SDRAM word transaction each. It holds every strobe until acknowledge arrives and returns read data or a completion and error status to the CPU. It sits between the CPU core and the `sdram_*` port of the SoC fabric.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles a strobe is held without acknowledge before the transaction is aborted; range 1..65535.
- `clk_clk`  in  1  system clock; all logic on the rising edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `mem_req`  in  1  CPU request valid.
- `mem_ready`  out  1  bridge can accept; a transfer occurs when `mem_req & mem_ready`.
- `mem_we`  in  1  1 = write, 0 = read.
- `mem_addr`  in  17  halfword address.
- `mem_be`  in  2  halfword byte enables; used for writes only.
- `mem_wdata`  in  16  write data.
- `mem_resp_valid`  out  1  one-cycle completion pulse, for both reads and writes.
- `mem_resp_err`  out  1  qualifies `mem_resp_valid`; timeout abort.
- `mem_rdata`  out  16  read data; valid with `mem_resp_valid` on a read.
- `sdram_address`  out  16  32-bit word address.
- `sdram_byte_enable`  out  4
- `sdram_read`, `sdram_write`  out  1 each
- `sdram_write_data`  out  32
- `sdram_acknowledge`  in  1
- `sdram_read_data`  in  32

## Operation
- States: IDLE, READ, WRITE, RESP.
- The request is captured in IDLE on a transfer.
- Mapping:
  - `sdram_address` = `mem_addr[16:1]`.
  - Write `sdram_byte_enable` = `mem_addr[0]` ? {`mem_be`, 2'b00} : {2'b00, `mem_be`}.
  - Read `sdram_byte_enable` = 4'b1111.
  - `sdram_write_data` = {`mem_wdata`, `mem_wdata`}.
  - `mem_rdata` = `mem_addr[0]` ? `read_data[31:16]` : `read_data[15:0]`, captured on acknowledge.
- READ/WRITE: the corresponding strobe is high. Address, byte enables and data are stable and registered for the whole transaction.
- On `sdram_acknowledge`: the strobe drops, data is latched, the FSM goes to RESP.
- On timeout: the strobe drops, the error flag is set, the FSM goes to RESP.
- RESP: `mem_resp_valid` = 1 for one cycle, then IDLE.
- A write with `mem_be` = 0 issues no bus cycle: IDLE goes directly to RESP, no error.
- `sdram_acknowledge` outside READ/WRITE is ignored.
- Acknowledge in the same cycle the timeout counter expires: acknowledge wins, no error.
- Reset mid-transaction aborts it. No response is issued and strobes drop immediately (asynchronous).
- Reset values: all outputs 0, except `mem_ready` = 1. Counter 0, state IDLE.

## Timing
- `mem_ready` is high only in IDLE and is combinational from state. Only one transaction is outstanding.
- The transfer occurs at edge T0. The strobe is high from T0 until the edge on which acknowledge is sampled high (Ta).
- An acknowledge sampled high on the first strobe cycle gives the minimum latency.
- Strobe low and RESP after Ta. `mem_resp_valid` is high in cycle Ta..Ta+1, then IDLE and `mem_ready` = 1 at Ta+1.
- Minimum transfer-to-response latency is 2 cycles. Back-to-back throughput is one access per 3 cycles.
- Timeout: the counter runs while a strobe is high. If there is no acknowledge within `TIMEOUT_CYCLES` strobe cycles, the strobe deasserts after exactly `TIMEOUT_CYCLES` cycles.
- `mem_rdata` holds its value until the next read response.

## Configuration
- `SDRAM_READ_BUFFER_EN` defined:
  - A one-entry buffer (valid, 16-bit word address, 32-bit data) is filled by every successful read.
  - A read hitting the buffer issues no SDRAM cycle: IDLE goes directly to RESP with buffered data, so the response follows the transfer by 1 cycle.
  - Any write to the buffered word address invalidates the buffer, including a write with `mem_be` = 0.
  - Timeout and reset also invalidate it.
- Macro undefined: no buffer. Every read goes to SDRAM.

## Structure
- Package `sdram_bridge_pkg`: state enum (IDLE, READ, WRITE, RESP), `SDRAM_AW` = 16, `SDRAM_DW` = 32, `CPU_AW` = 17, `CPU_DW` = 16.
- Sub-module `sdram_read_buffer` (only instantiated under `SDRAM_READ_BUFFER_EN`). It provides lookup, fill and invalidate ports.
- FSM, timeout counter and lane mapping live in the top module.

## Test plan
- Read `mem_addr` = 17'h00003, slave acknowledges on the 3rd strobe cycle with 32'hDEADBEEF -> `sdram_address` = 16'h0001, byte_enable = 4'hF, `mem_rdata` = 16'hDEAD, `mem_resp_err` = 0.
- Write `mem_addr` = 17'h00010, `mem_be` = 2'b01, `mem_wdata` = 16'h1234 -> byte_enable = 4'b0001, write_data = 32'h12341234, strobe held until acknowledge, then one response pulse.
- `TIMEOUT_CYCLES` = 4, slave never acknowledges -> strobe high for exactly 4 cycles, response with `mem_resp_err` = 1. Acknowledge arriving on cycle 4 instead -> no error.
- Write with `mem_be` = 0 -> no `sdram_write` assertion, response 1 cycle after transfer. Stray acknowledge while idle -> no response.
- Assert reset with `sdram_read` high -> strobe low asynchronously, no `mem_resp_valid`, `mem_ready` = 1 after release.
- With `SDRAM_READ_BUFFER_EN`: read 17'h00020, reread 17'h00021 -> no bus cycle, upper half returned in 1 cycle. Write 17'h00020, then read -> SDRAM read issued again.
